// File: rtl/arm_fpga_latency_timer_pkg.sv
// Shared types and field positions for the ARM->FPGA latency timer.
package arm_fpga_latency_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int CNT_LSB = 0;

    function automatic int done_bit(input int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic int ovf_bit(input int cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/arm_fpga_latency_timer_if.sv
// Strobe inputs and the published result word of the latency timer.
interface arm_fpga_latency_timer_if #(
    parameter int CNT_W = 8
);
    logic               arm_start;
    logic               fpga_stop;
    logic               busy;
    logic [CNT_W+1:0]   pio_data;

    modport master (output arm_start, output fpga_stop, input busy, input pio_data);
    modport slave  (input arm_start, input fpga_stop, output busy, output pio_data);
endinterface

// File: rtl/arm_fpga_latency_timer_sync_rise_detect.sv
// Optional 2-flop synchronizer followed by a single-cycle rising-edge detector.
module sync_rise_detect #(
    parameter int SYNC_EN = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);
    localparam int NS = (SYNC_EN != 0) ? 2 : 0;
    localparam int NV = NS + 1;

    logic          sync;
    logic          prev;
    logic [NV-1:0] vld_pipe;

    generate
        if (NS > 0) begin : g_sync
            logic [1:0] ff;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) ff <= '0;
                else          ff <= {ff[0], d};
            end
            assign sync = ff[1];
        end else begin : g_nosync
            assign sync = d;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= 1'b0;
            vld_pipe <= '0;
        end else begin
            prev     <= sync;
            vld_pipe <= (vld_pipe << 1) | NV'(1);
        end
    end

    // A level already high when reset releases is not an edge: suppress pulses
    // until prev holds a real sample.
    assign pulse = sync & ~prev & vld_pipe[NV-1];

endmodule

// File: rtl/arm_fpga_latency_timer.sv
// Counts clk cycles (optionally prescaled) from an HPS start edge to an FPGA stop edge
// and publishes {done, overflow, count} as a static word for the input PIO.
module arm_fpga_latency_timer
    import arm_fpga_latency_timer_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1,
    parameter int SYNC_EN  = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    arm_fpga_latency_timer_if.slave     tmr
);
    localparam int TICK_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DONE_BIT = done_bit(CNT_W);
    localparam int OVF_BIT  = ovf_bit(CNT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(PRESCALE - 1);

    logic start_pulse, stop_pulse;

    sync_rise_detect #(.SYNC_EN(SYNC_EN)) u_start (
        .clk(clk), .reset_n(reset_n), .d(tmr.arm_start), .pulse(start_pulse)
    );
    sync_rise_detect #(.SYNC_EN(SYNC_EN)) u_stop (
        .clk(clk), .reset_n(reset_n), .d(tmr.fpga_stop), .pulse(stop_pulse)
    );

    state_e             state, state_nxt;
    logic [TICK_W-1:0]  tick, tick_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_adv;
    logic [CNT_W+1:0]   pio, pio_nxt;
    logic               cnt_step;
    logic               busy_q;

    // cnt_adv is the value cnt takes at this edge; capturing it keeps the result exact.
    assign cnt_step = (tick == TICK_TOP);
    assign cnt_adv  = (cnt_step && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        cnt_nxt   = cnt;
        pio_nxt   = pio;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_pulse) begin
                    state_nxt         = ST_COUNT;
                    tick_nxt          = '0;
                    cnt_nxt           = '0;
                    pio_nxt[DONE_BIT] = 1'b0;
                    pio_nxt[OVF_BIT]  = 1'b0;
                end
            end
            ST_COUNT: begin
                tick_nxt = cnt_step ? '0 : tick + 1'b1;
                cnt_nxt  = cnt_adv;
                if (stop_pulse) begin
                    state_nxt = ST_DONE;
                    pio_nxt   = {1'b1, 1'b0, cnt_adv};
                end else if (cnt_adv == CNT_MAX) begin
                    state_nxt = ST_DONE;
                    pio_nxt   = {1'b1, 1'b1, CNT_MAX};
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            tick   <= '0;
            cnt    <= '0;
            pio    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            tick   <= tick_nxt;
            cnt    <= cnt_nxt;
            pio    <= pio_nxt;
            busy_q <= (state_nxt == ST_COUNT);
        end
    end

    assign tmr.busy     = busy_q;
    assign tmr.pio_data = pio;

endmodule
